// File: rtl/kgp_pkg.sv
// ============================================================================
// Module : kgp_pkg
// Desc   : Shared KGP_RISC fetch-path constants and next-PC state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package kgp_pkg;

   localparam int         PC_W      = 8;
   localparam logic [7:0] RESET_VEC = 8'h00;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      PEND = 2'd1,
      HALT = 2'd2
   } npc_state_t;

endpackage : kgp_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Desc   : Saturating up-counter, asynchronous active-low clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign cnt = r_cnt;

endmodule : sat_counter

`default_nettype wire

// File: rtl/next_pc_unit.sv
// ============================================================================
// Module : next_pc_unit
// Desc   : Next-PC generation: increment, branch redirect, stall with pending
//          redirect buffer, terminal halt. Optional perf counters: NPC_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module next_pc_unit
   import kgp_pkg::*;
#(
   parameter int              PC_W      = kgp_pkg::PC_W,
   parameter logic [PC_W-1:0] RESET_VEC = kgp_pkg::RESET_VEC,
   parameter int              CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PC_W-1:0]  pc_cur,
   input  logic             stall,
   input  logic             br_valid,
   input  logic             br_taken,
   input  logic [PC_W-1:0]  br_target,
   input  logic             halt,
   output logic [PC_W-1:0]  pc_next,
   output logic             flush,
   output logic             halted,
   output logic [CNT_W-1:0] redirect_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   npc_state_t      r_state;
   logic [PC_W-1:0] r_pend_tgt;

   npc_state_t      w_state_nxt;
   logic [PC_W-1:0] w_pc_next;
   logic            w_flush;
   logic            w_capture;
   logic            w_redir;
   logic [PC_W-1:0] w_pc_inc;

   assign w_redir  = br_valid & br_taken;
   assign w_pc_inc = pc_cur + {{(PC_W-1){1'b0}}, 1'b1};

   always_comb begin
      w_state_nxt = r_state;
      w_pc_next   = pc_cur;
      w_flush     = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         RUN: begin
            if (w_redir && !stall) begin
               w_pc_next = br_target;
               w_flush   = 1'b1;
            end else if (w_redir) begin
               w_capture   = 1'b1;
               w_state_nxt = PEND;
            end else if (stall) begin
               w_pc_next = pc_cur;
            end else if (halt) begin
               w_state_nxt = HALT;
            end else begin
               w_pc_next = w_pc_inc;
            end
         end
         // Younger redirects seen while pending are wrong-path and dropped.
         PEND: begin
            if (!stall) begin
               w_pc_next   = r_pend_tgt;
               w_flush     = 1'b1;
               w_state_nxt = RUN;
            end
         end
         HALT: begin
            w_pc_next = pc_cur;
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= RUN;
         r_pend_tgt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_pend_tgt <= br_target;
         end
      end
   end

   // The PC register has no reset of its own, so reset is forced through here.
   assign pc_next = rst_n ? w_pc_next : RESET_VEC;
   assign flush   = rst_n & w_flush;
   assign halted  = rst_n & (r_state == HALT);

`ifdef NPC_PERF_EN
   logic w_stall_inc;

   assign w_stall_inc = stall & (r_state != HALT);

   sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush),
      .cnt   (redirect_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_stall_inc),
      .cnt   (stall_cnt)
   );
`else
   assign redirect_cnt = '0;
   assign stall_cnt    = '0;
`endif

endmodule : next_pc_unit

`default_nettype wire

// File: tb/tb_next_pc_unit.sv
// ============================================================================
// Module : tb_next_pc_unit
// Desc   : Directed self-checking bench for next_pc_unit with a PC register loop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_next_pc_unit;

   localparam int PC_W  = 8;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst_n;
   logic [PC_W-1:0]  pc_reg;
   logic             stall;
   logic             br_valid;
   logic             br_taken;
   logic [PC_W-1:0]  br_target;
   logic             halt;
   logic [PC_W-1:0]  pc_next;
   logic             flush;
   logic             halted;
   logic [CNT_W-1:0] redirect_cnt;
   logic [CNT_W-1:0] stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   next_pc_unit #(.PC_W(PC_W), .RESET_VEC(8'h00), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_cur       (pc_reg),
      .stall        (stall),
      .br_valid     (br_valid),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .halt         (halt),
      .pc_next      (pc_next),
      .flush        (flush),
      .halted       (halted),
      .redirect_cnt (redirect_cnt),
      .stall_cnt    (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC register without reset or enable, closing the loop.
   always_ff @(posedge clk) pc_reg <= pc_next;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      br_valid  = 1'b0;
      br_taken  = 1'b0;
      halt      = 1'b0;
      #1;
   endtask

   task automatic redirect(input logic [PC_W-1:0] tgt);
      br_valid  = 1'b1;
      br_taken  = 1'b1;
      br_target = tgt;
      #1;
   endtask

   logic [CNT_W-1:0] exp_scnt;
   logic [CNT_W-1:0] exp_rcnt;

   initial begin
      rst_n     = 1'b0;
      stall     = 1'b0;
      br_valid  = 1'b0;
      br_taken  = 1'b0;
      br_target = '0;
      halt      = 1'b0;

      // Reset held for 3 clocks
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_pc_next", pc_next, 8'h00);
      chk("rst_pc_cur", pc_reg, 8'h00);
      chk("rst_flush", flush, 0);
      chk("rst_halted", halted, 0);
      chk("rst_rcnt", redirect_cnt, 0);
      chk("rst_scnt", stall_cnt, 0);

      // Free-run after release; br_taken alone must be ignored
      rst_n = 1'b1;
      br_taken = 1'b1; br_target = 8'hAA; #1;
      chk("run0_pc", pc_reg, 8'h00);
      chk("run0_flush", flush, 0);
      chk("taken_novalid", pc_next, 8'h01);
      step(); chk("run1_pc", pc_reg, 8'h01);
      step(); chk("run2_pc", pc_reg, 8'h02);
      step(); chk("run3_pc", pc_reg, 8'h03);
      chk("run3_flush", flush, 0);

      // Wrap-around
      for (int i = 0; i < 300 && pc_reg != 8'hFE; i++) step();
      chk("reach_fe", pc_reg, 8'hFE);
      step(); chk("wrap_ff", pc_reg, 8'hFF);
      chk("wrap_next", pc_next, 8'h00);
      step(); chk("wrap_00", pc_reg, 8'h00);

      // Direct redirect at 0x10
      for (int i = 0; i < 300 && pc_reg != 8'h10; i++) step();
      chk("reach_10", pc_reg, 8'h10);
      redirect(8'h40);
      chk("dir_flush", flush, 1);
      chk("dir_next", pc_next, 8'h40);
      step(); chk("dir_pc40", pc_reg, 8'h40);
      chk("dir_flush_off", flush, 0);
      step(); chk("dir_pc41", pc_reg, 8'h41);

      // Redirect to 0x20, then redirect during a 3-cycle stall
      redirect(8'h20);
      step(); chk("reach_20", pc_reg, 8'h20);
      stall = 1'b1; redirect(8'h80);
      chk("st1_flush", flush, 0);
      chk("st1_next", pc_next, 8'h20);
      step(); stall = 1'b1; redirect(8'h90);
      chk("st2_pc", pc_reg, 8'h20);
      chk("st2_flush", flush, 0);
      chk("st2_next", pc_next, 8'h20);
      step(); chk("st3_pc", pc_reg, 8'h20);
      chk("st3_flush", flush, 0);
      step(); stall = 1'b0; #1;
      chk("pend_pc", pc_reg, 8'h20);
      chk("pend_flush", flush, 1);
      chk("pend_next", pc_next, 8'h80);
      step(); chk("pend_pc80", pc_reg, 8'h80);
      chk("pend_flush_off", flush, 0);
`ifdef NPC_PERF_EN
      exp_scnt = 16'd3; exp_rcnt = 16'd3;
`else
      exp_scnt = 16'd0; exp_rcnt = 16'd0;
`endif
      chk("stall_cnt", stall_cnt, exp_scnt);
      chk("redirect_cnt", redirect_cnt, exp_rcnt);

      // Halt together with redirect: redirect wins
      halt = 1'b1; redirect(8'h05);
      chk("hr_flush", flush, 1);
      chk("hr_next", pc_next, 8'h05);
      step(); chk("hr_pc05", pc_reg, 8'h05);
      chk("hr_halted", halted, 0);
      step(); chk("hr_pc06", pc_reg, 8'h06);
      step(); chk("hr_pc07", pc_reg, 8'h07);
      halt = 1'b1; #1;
      chk("halt_next", pc_next, 8'h07);
      step(); redirect(8'h55);
      chk("halted", halted, 1);
      chk("halt_pc", pc_reg, 8'h07);
      chk("halt_redir_next", pc_next, 8'h07);
      chk("halt_flush", flush, 0);
      step(); stall = 1'b1; #1;
      chk("halt_pc2", pc_reg, 8'h07);
      step(); stall = 1'b0; #1;
      chk("halt_pc3", pc_reg, 8'h07);
      chk("halt_scnt", stall_cnt, exp_scnt);
      rst_n = 1'b0; #1;
      chk("hrst_next", pc_next, 8'h00);
      chk("hrst_halted", halted, 0);
      step(); chk("hrst_pc", pc_reg, 8'h00);
      rst_n = 1'b1; #1;
      chk("hrst_halted2", halted, 0);
      chk("hrst_rel_next", pc_next, 8'h01);

      // Asynchronous reset while in PEND
      stall = 1'b1; redirect(8'h33);
      step(); stall = 1'b1; #1;
      chk("ap_pc", pc_reg, 8'h00);
      #2 rst_n = 1'b0; #1;
      chk("ap_rst_next", pc_next, 8'h00);
      chk("ap_rst_flush", flush, 0);
      step(); stall = 1'b0; rst_n = 1'b1; #1;
      chk("ap_flush", flush, 0);
      chk("ap_pc0", pc_reg, 8'h00);
      chk("ap_next", pc_next, 8'h01);
      step(); chk("ap_pc1", pc_reg, 8'h01);
      step(); chk("ap_pc2", pc_reg, 8'h02);
      chk("ap_flush2", flush, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_next_pc_unit

`default_nettype wire
